// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the state encoding, frame-length codes, FIFO entry layout and divider floor.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_t;

    localparam logic [1:0] LEN_5 = 2'b00;
    localparam logic [1:0] LEN_6 = 2'b01;
    localparam logic [1:0] LEN_7 = 2'b10;
    localparam logic [1:0] LEN_8 = 2'b11;

    localparam int MIN_DIVIDER = 4;

    localparam int ENTRY_WIDTH    = 11;
    localparam int DATA_LSB       = 0;
    localparam int DATA_MSB       = 7;
    localparam int FRAME_ERR_BIT  = 8;
    localparam int PARITY_ERR_BIT = 9;
    localparam int BREAK_BIT      = 10;

    // Index of the last data bit shifted in for a given length code.
    function automatic logic [2:0] last_bit_index(input logic [1:0] code);
        logic [2:0] idx;
        case (code)
            LEN_5:   idx = 3'd4;
            LEN_6:   idx = 3'd5;
            LEN_7:   idx = 3'd6;
            LEN_8:   idx = 3'd7;
            default: idx = 3'd7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy level.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)
                level <= level + LW'(1);
            else if (do_pop && !do_push)
                level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with run-time frame format, 3-sample majority voting and break detection,
// feeding a receive FIFO that the host drains through a valid/ready pop interface.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int DIVIDER_WIDTH = 16,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic                         serial_i,
    input  logic [DIVIDER_WIDTH-1:0]     clock_divider_i,
    input  logic [1:0]                   data_bits_i,
    input  logic                         parity_en_i,
    input  logic                         parity_even_i,
    input  logic                         stop_bits_i,
    output logic [7:0]                   data_o,
    output logic                         frame_err_o,
    output logic                         parity_err_o,
    output logic                         break_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         overrun_o,
    input  logic                         clear_overrun_i,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
    output logic                         busy_o
);

    localparam logic [DIVIDER_WIDTH-1:0] ONE = DIVIDER_WIDTH'(1);

    rx_state_t state, state_next;

    logic                     sync_meta;
    logic                     line;
    logic [DIVIDER_WIDTH-1:0] timer;
    logic [DIVIDER_WIDTH-1:0] div;
    logic [DIVIDER_WIDTH-1:0] half;
    logic [1:0]               len_code;
    logic                     par_en;
    logic                     par_even;
    logic                     two_stop;
    logic [7:0]               shift;
    logic [2:0]               bit_idx;
    logic                     stop_idx;
    logic                     samp_a;
    logic                     samp_b;
    logic                     par_bit;
    logic                     par_err;
    logic                     frame_err;

    logic                     start_seen;
    logic                     at_decision;
    logic                     bit_val;
    logic                     last_stop;
    logic                     frame_err_final;
    logic                     brk;
    logic                     expected_par;
    logic [ENTRY_WIDTH-1:0]   entry;
    logic [ENTRY_WIDTH-1:0]   head;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     pop;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_meta <= 1'b1;
            line      <= 1'b1;
        end else begin
            sync_meta <= serial_i;
            line      <= sync_meta;
        end
    end

    assign half            = div >> 1;
    assign at_decision     = (timer == half - ONE);
    assign bit_val         = (samp_a & samp_b) | (samp_a & line) | (samp_b & line);
    assign start_seen      = (state == ST_IDLE) && !line &&
                             (clock_divider_i >= DIVIDER_WIDTH'(MIN_DIVIDER));
    assign last_stop       = (state == ST_STOP) && at_decision && (stop_idx || !two_stop);
    assign frame_err_final = frame_err | !bit_val;
    assign brk             = (shift == 8'h00) && !(par_en && par_bit) && frame_err_final;
    assign expected_par    = par_even ? ^shift : ~^shift;
    assign entry           = {brk, par_err, frame_err_final, shift};

    // Configuration is captured at the start edge so mid-frame changes cannot corrupt a frame.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            timer     <= '0;
            div       <= '0;
            len_code  <= LEN_8;
            par_en    <= 1'b0;
            par_even  <= 1'b0;
            two_stop  <= 1'b0;
            shift     <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
        end else if (start_seen) begin
            div       <= clock_divider_i;
            timer     <= clock_divider_i - ONE;
            len_code  <= data_bits_i;
            par_en    <= parity_en_i;
            par_even  <= parity_even_i;
            two_stop  <= stop_bits_i;
            shift     <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
        end else if (state != ST_IDLE) begin
            timer <= (timer == '0) ? div - ONE : timer - ONE;
            if (timer == half + ONE) samp_a <= line;
            if (timer == half)       samp_b <= line;
            if (at_decision) begin
                case (state)
                    ST_DATA: begin
                        shift[bit_idx] <= bit_val;
                        bit_idx        <= bit_idx + 3'd1;
                    end
                    ST_PARITY: begin
                        par_bit <= bit_val;
                        par_err <= (bit_val != expected_par);
                    end
                    ST_STOP: begin
                        stop_idx <= 1'b1;
                        if (!bit_val) frame_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= ST_IDLE;
        else            state <= state_next;
    end

    // Leaving STOP at mid-bit lets a back-to-back start bit be caught.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:       if (start_seen) state_next = ST_START;
            ST_START:      if (at_decision) state_next = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:       if (at_decision && (bit_idx == last_bit_index(len_code)))
                               state_next = par_en ? ST_PARITY : ST_STOP;
            ST_PARITY:     if (at_decision) state_next = ST_STOP;
            ST_STOP:       if (last_stop) state_next = brk ? ST_BREAK_WAIT : ST_IDLE;
            ST_BREAK_WAIT: if (line) state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    assign valid_o = !fifo_empty;
    assign pop     = valid_o && ready_i;

    uart_sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock_i),
        .rst_n     (reset_n_i),
        .push      (last_stop),
        .push_data (entry),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level_o)
    );

    assign data_o       = valid_o ? head[DATA_MSB:DATA_LSB] : 8'h00;
    assign frame_err_o  = valid_o && head[FRAME_ERR_BIT];
    assign parity_err_o = valid_o && head[PARITY_ERR_BIT];
    assign break_o      = valid_o && head[BREAK_BIT];
    assign busy_o       = (state != ST_IDLE);

    // A new overrun wins over a coincident clear.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)
            overrun_o <= 1'b0;
        else if (last_stop && fifo_full && !pop)
            overrun_o <= 1'b1;
        else if (clear_overrun_i)
            overrun_o <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: directed frames plus randomized formats,
// each compared against a frame-level model and an ideal bounded FIFO.
module tb_uart_rx_buffered;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic       brk;
        logic       pe;
        logic       fe;
        logic [7:0] data;
    } entry_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          serial = 1'b1;
    logic [DW-1:0] clock_divider = DW'(16);
    logic [1:0]    data_bits = 2'b11;
    logic          parity_en = 1'b0;
    logic          parity_even = 1'b0;
    logic          stop_bits = 1'b0;
    logic [7:0]    data;
    logic          frame_err;
    logic          parity_err;
    logic          break_flag;
    logic          valid;
    logic          ready = 1'b0;
    logic          overrun;
    logic          clear_overrun = 1'b0;
    logic [LW-1:0] fifo_level;
    logic          busy;

    entry_t expected_q[$];
    bit     model_overrun = 1'b0;
    int     compared = 0;
    int     mismatched = 0;

    uart_rx_buffered #(
        .DIVIDER_WIDTH (DW),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clock_i         (clock),
        .reset_n_i       (reset_n),
        .serial_i        (serial),
        .clock_divider_i (clock_divider),
        .data_bits_i     (data_bits),
        .parity_en_i     (parity_en),
        .parity_even_i   (parity_even),
        .stop_bits_i     (stop_bits),
        .data_o          (data),
        .frame_err_o     (frame_err),
        .parity_err_o    (parity_err),
        .break_o         (break_flag),
        .valid_o         (valid),
        .ready_i         (ready),
        .overrun_o       (overrun),
        .clear_overrun_i (clear_overrun),
        .fifo_level_o    (fifo_level),
        .busy_o          (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Ideal bounded FIFO: frames arriving when full are lost and flag an overrun.
    task automatic model_push(input entry_t e);
        if (expected_q.size() < DEPTH) expected_q.push_back(e);
        else                           model_overrun = 1'b1;
    endtask

    // Edge (counted from the start-bit fall) at which the final stop decision pushes:
    // 2 synchroniser flops + detect edge, then the third sample at timer div/2-1.
    function automatic int push_edge(input int div, input int frame_len);
        return 4 + div - div / 2 + (frame_len - 1) * div;
    endfunction

    // Drives one frame starting right after a negedge, then an idle gap; queues the expected entry.
    task automatic applyStimulus(input logic [7:0] value, input int nbits, input bit p_en,
                                 input bit p_even, input bit stop2, input bit flip_par,
                                 input bit [1:0] stop_vals, input int div, input int gap_bits,
                                 input bit glitch);
        bit         frame_bits[$];
        bit         pbit;
        bit         fe;
        logic [7:0] masked;
        entry_t     e;
        int         mid;
        masked = value & 8'((1 << nbits) - 1);
        pbit   = (($countones(masked) % 2) == 1) ^ !p_even ^ flip_par;
        fe     = !stop_vals[0] || (stop2 && !stop_vals[1]);
        e.data = masked;
        e.pe   = p_en && flip_par;
        e.fe   = fe;
        e.brk  = (masked == 8'h00) && (!p_en || !pbit) && fe;
        clock_divider = DW'(div);
        data_bits     = 2'(nbits - 5);
        parity_en     = p_en;
        parity_even   = p_even;
        stop_bits     = stop2;
        frame_bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) frame_bits.push_back(masked[i]);
        if (p_en) frame_bits.push_back(pbit);
        frame_bits.push_back(stop_vals[0]);
        if (stop2) frame_bits.push_back(stop_vals[1]);
        mid = div - div / 2 + 1;
        foreach (frame_bits[b]) begin
            for (int c = 1; c <= div; c++) begin
                serial = (glitch && b >= 1 && b <= nbits && c == mid) ? ~frame_bits[b] : frame_bits[b];
                @(negedge clock);
            end
        end
        model_push(e);
        serial = 1'b1;
        repeat (gap_bits * div) @(negedge clock);
    endtask

    task automatic drain_fifo(input string tag);
        entry_t e;
        while (expected_q.size() > 0) begin
            e = expected_q[0];
            checkOutput({tag, ".level"}, 32'(fifo_level), 32'(expected_q.size()));
            checkOutput({tag, ".valid"}, 32'(valid), 1);
            checkOutput({tag, ".data"}, 32'(data), 32'(e.data));
            checkOutput({tag, ".flags"}, {29'd0, break_flag, parity_err, frame_err},
                        {29'd0, e.brk, e.pe, e.fe});
            ready = 1'b1;
            @(negedge clock);
            ready = 1'b0;
            void'(expected_q.pop_front());
        end
        checkOutput({tag, ".empty_valid"}, 32'(valid), 0);
        checkOutput({tag, ".empty_level"}, 32'(fifo_level), 0);
        checkOutput({tag, ".empty_data"}, 32'(data), 0);
    endtask

    initial begin
        int         nb;
        int         div;
        bit         r_pen;
        bit         r_peven;
        bit         r_stop2;
        bit         r_flip;
        bit         r_glitch;
        bit [1:0]   r_stops;
        logic [7:0] r_data;
        entry_t     brk_entry;

        repeat (3) @(negedge clock);
        checkOutput("reset.valid", 32'(valid), 0);
        checkOutput("reset.level", 32'(fifo_level), 0);
        checkOutput("reset.busy", 32'(busy), 0);
        checkOutput("reset.overrun", 32'(overrun), 0);
        checkOutput("reset.data", 32'(data), 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        // 8N1 0xA5 with push timing
        fork
            applyStimulus(8'hA5, 8, 0, 0, 0, 0, 2'b11, 16, 2, 0);
            begin
                repeat (push_edge(16, 10) - 1) @(negedge clock);
                checkOutput("a5.level_before_push", 32'(fifo_level), 0);
                @(negedge clock);
                checkOutput("a5.level_at_push", 32'(fifo_level), 1);
            end
        join
        drain_fifo("a5");

        applyStimulus(8'h41, 7, 1, 1, 0, 1, 2'b11, 16, 2, 0);
        drain_fifo("7e1_bad_parity");

        applyStimulus(8'h15, 5, 1, 0, 1, 0, 2'b01, 16, 2, 0);
        drain_fifo("5o2_bad_stop");

        // Break: line low for 12 bit times
        clock_divider = DW'(16);
        data_bits     = 2'b11;
        parity_en     = 1'b0;
        stop_bits     = 1'b0;
        serial        = 1'b0;
        repeat (12 * 16) @(negedge clock);
        checkOutput("brk.busy_while_low", 32'(busy), 1);
        checkOutput("brk.level", 32'(fifo_level), 1);
        serial = 1'b1;
        repeat (2 * 16) @(negedge clock);
        checkOutput("brk.busy_after_high", 32'(busy), 0);
        brk_entry = '{brk: 1'b1, pe: 1'b0, fe: 1'b1, data: 8'h00};
        model_push(brk_entry);
        drain_fifo("brk");

        // Overrun with a depth-4 FIFO
        for (int i = 1; i <= 5; i++)
            applyStimulus(8'(i), 8, 0, 0, 0, 0, 2'b11, 16, 2, 0);
        checkOutput("ovr.level", 32'(fifo_level), 32'(expected_q.size()));
        checkOutput("ovr.set", 32'(overrun), 32'(model_overrun));
        checkOutput("ovr.head", 32'(data), 32'(expected_q[0].data));
        clear_overrun = 1'b1;
        @(negedge clock);
        clear_overrun = 1'b0;
        model_overrun = 1'b0;
        checkOutput("ovr.cleared", 32'(overrun), 0);
        void'(expected_q.pop_front());
        fork
            applyStimulus(8'h06, 8, 0, 0, 0, 0, 2'b11, 16, 2, 0);
            begin
                repeat (push_edge(16, 10) - 1) @(negedge clock);
                ready = 1'b1;
                @(negedge clock);
                ready = 1'b0;
            end
        join
        checkOutput("ovr.pop_push_overrun", 32'(overrun), 32'(model_overrun));
        drain_fifo("ovr");

        // Short glitch is rejected at the start-bit majority
        serial = 1'b0;
        repeat (3) @(negedge clock);
        serial = 1'b1;
        checkOutput("glitch.busy_in_start", 32'(busy), 1);
        repeat (2 * 16) @(negedge clock);
        checkOutput("glitch.busy_after", 32'(busy), 0);
        checkOutput("glitch.level", 32'(fifo_level), 0);

        // Divider below the minimum keeps the receiver idle
        clock_divider = DW'(3);
        serial = 1'b0;
        repeat (10) @(negedge clock);
        checkOutput("div3.busy", 32'(busy), 0);
        serial = 1'b1;
        repeat (10) @(negedge clock);
        checkOutput("div3.level", 32'(fifo_level), 0);
        clock_divider = DW'(16);

        // Reset mid-DATA with an entry already buffered
        applyStimulus(8'h77, 8, 0, 0, 0, 0, 2'b11, 16, 2, 0);
        data_bits = 2'b11;
        parity_en = 1'b0;
        stop_bits = 1'b0;
        serial    = 1'b0;
        repeat (16) @(negedge clock);
        serial = 1'b1;
        repeat (16) @(negedge clock);
        serial = 1'b0;
        repeat (8) @(negedge clock);
        checkOutput("rst.busy_before", 32'(busy), 1);
        reset_n = 1'b0;
        serial  = 1'b1;
        expected_q.delete();
        model_overrun = 1'b0;
        @(negedge clock);
        checkOutput("rst.valid", 32'(valid), 0);
        checkOutput("rst.level", 32'(fifo_level), 0);
        checkOutput("rst.busy", 32'(busy), 0);
        checkOutput("rst.data", 32'(data), 0);
        checkOutput("rst.flags", {29'd0, break_flag, parity_err, frame_err}, 0);
        checkOutput("rst.overrun", 32'(overrun), 0);
        reset_n = 1'b1;
        repeat (3 * 16) @(negedge clock);
        applyStimulus(8'h3C, 8, 0, 0, 0, 0, 2'b11, 16, 2, 0);
        drain_fifo("rst_3c");

        // Randomized formats, dividers, error injection and mid-sample glitches
        for (int n = 0; n < 24; n++) begin
            nb       = $urandom_range(8, 5);
            div      = $urandom_range(20, 4);
            r_pen    = 1'($urandom_range(1, 0));
            r_peven  = 1'($urandom_range(1, 0));
            r_stop2  = 1'($urandom_range(1, 0));
            r_flip   = ($urandom_range(3, 0) == 0);
            r_glitch = ($urandom_range(2, 0) == 0);
            r_data   = 8'($urandom);
            if ($urandom_range(7, 0) == 0) r_data = 8'h00;
            r_stops  = 2'b11;
            if ($urandom_range(5, 0) == 0) r_stops[$urandom_range(1, 0)] = 1'b0;
            applyStimulus(r_data, nb, r_pen, r_peven, r_stop2, r_flip, r_stops, div, 2, r_glitch);
            if (expected_q.size() >= 3) drain_fifo("rand");
        end
        drain_fifo("rand");
        checkOutput("rand.overrun", 32'(overrun), 32'(model_overrun));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Parametrised successor UART receiver with run-time frame format (5–8 data bits, optional even/odd parity, 1 or 2 stop bits), 3-sample majority voting, break detection, and a receive FIFO with per-entry error flags. It sits between the serial pin and the host bus, so the host reads bytes through a valid/ready pop interface instead of a single-byte acknowledge.

## Interface
- DIVIDER_WIDTH, 16: width of `clock_divider_i` and the bit timer.
- FIFO_DEPTH, 16: entries in the receive FIFO; power of two, ≥2.
- clock_i  in  1  system clock; all logic is on the rising edge.
- reset_n_i  in  1  reset, asynchronous and active-low.
- serial_i  in  1  UART line, asynchronous; idle high.
- clock_divider_i  in  DIVIDER_WIDTH  clocks per bit; values below 4 keep the receiver in IDLE.
- data_bits_i  in  2  data length: 00=5, 01=6, 10=7, 11=8.
- parity_en_i  in  1  enables the parity bit.
- parity_even_i  in  1  selects even parity (1) or odd parity (0).
- stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits.
- data_o  out  8  FIFO head data, LSB-aligned, unused upper bits 0.
- frame_err_o / parity_err_o / break_o  out  1 each  FIFO head flags.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  pops the head entry when `valid_o && ready_i`.
- overrun_o  out  1  sticky: a frame was dropped because the FIFO was full.
- clear_overrun_i  in  1  clears `overrun_o`.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- busy_o  out  1  high whenever the state is not IDLE.

## Operation
- Input path: `serial_i` passes through a 2-flop synchroniser. Both flops reset to 1.
- Configuration inputs (divider, data bits, parity, stop bits) are latched when the start edge is detected. Changes mid-frame are ignored.
- Bit timer:
  - Loads `div-1` and counts down to 0, then reloads.
  - Samples are taken at timer values `div/2+1`, `div/2` and `div/2-1`.
  - The bit value is the majority of the three samples, decided at `div/2-1`.
  - Arithmetic is unsigned and wraps at DIVIDER_WIDTH.
- States:
  - IDLE: a synchronised low with `div≥4` moves to START.
  - START: majority 1 means a glitch; return to IDLE with no push. Otherwise go to DATA.
  - DATA: shift bits in LSB first, N bits. Then go to PARITY if enabled, else STOP.
  - PARITY: compare against the XOR of the data bits (inverted for odd parity); a mismatch sets parity_err.
  - STOP: sample one or two stop bits; any 0 sets frame_err. At the final stop sample, push to the FIFO. Go to BREAK_WAIT if break, else IDLE.
  - BREAK_WAIT: stay until the synchronised line is 1, then go to IDLE.
- Break is all data bits 0, the parity bit 0 (if enabled) and a stop bit 0. The frame is pushed with data 0x00, break=1 and frame_err=1.
- FIFO entry is 11 bits: {break, parity_err, frame_err, data[7:0]}.
- Push into a full FIFO: the frame is dropped and `overrun_o` is set.
  - If a pop occurs in the same cycle, the push is accepted.
  - `clear_overrun_i` coincident with a new overrun leaves `overrun_o` set.
- Simultaneous push and pop at any level: the level is unchanged.
- Empty FIFO: `valid_o` is 0 and the head outputs read 0.
- Reset values: all outputs 0, `fifo_level_o` 0, state IDLE, FIFO pointers 0. Reset mid-frame discards the partial frame.

## Timing
- Start detection occurs 2 cycles after the `serial_i` fall, due to the synchroniser.
- Push happens on the edge after the final stop majority decision. `valid_o`, `fifo_level_o` and the head outputs update on that same edge.
- Return to IDLE is at mid-stop-bit, so a back-to-back start bit is caught.
- A pop takes effect on the edge where `valid_o && ready_i`. The next head appears on that edge; there is no bubble.
- `busy_o` rises on the edge that leaves IDLE and falls on the edge that enters IDLE.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding;
  - data-length codes;
  - the FIFO entry field offsets;
  - the minimum divider constant, 4.
- Sub-module `uart_sync_fifo` (parameters WIDTH, DEPTH) is a first-word-fall-through FIFO with a level output. It is reusable by the transmitter.

## Test plan
- 8N1, div=16, byte 0xA5 → one entry: data 0xA5, all flags 0, level 1. Pop → level 0, `valid_o` 0.
- 7E1, div=16, 0x41 sent with the parity bit inverted → data 0x41, parity_err=1, frame_err=0.
- 5O2 with a second stop bit of 0 on byte 0x15 → data 0x15, frame_err=1, break=0.
- Line held low for 12 bit times, then high → exactly one entry: 0x00, break=1, frame_err=1; `busy_o` stays high until the line returns high.
- FIFO_DEPTH=4, five 8N1 bytes 0x01–0x05, no pops → level 4, entries 0x01–0x04, `overrun_o`=1. `clear_overrun_i` → 0. Pop at the push cycle of a sixth byte (0x06) → that byte is accepted.
- Low glitch of 3 cycles at div=16 → no entry, `busy_o` back to 0. Separately, `reset_n_i` pulsed mid-DATA → all outputs 0, and the next 0x3C frame is received cleanly.
